// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Lets two requesters share one single-ported 32-bit data memory.
//   Port 0 is the core load/store unit and port 1 is the DMA/debug loader.
//   At most one access is granted per cycle. Read data comes back registered,
//   one cycle after the grant. Any address at or above DEPTH is still granted,
//   but it never writes the memory and it answers with err=1 and rdata=0.
//
// Parameters
//   DEPTH         number of 32-bit words in the memory (legal addr 0..DEPTH-1)
//   CORE_PRIORITY 1 = port 0 has priority, with a starvation guard for port 1
//                 0 = round-robin
//   MAX_WAIT      number of consecutive denied cycles after which port 1 is
//                 forced to win (1..15)
//
// Ports
//   clk, rst                       clock; asynchronous active-high reset
//   req/we/addr/wdata{0,1}         request side of each port (held until gnt)
//   gnt{0,1}                       combinational grant
//   rvalid/rdata/err{0,1}          registered response, one cycle after grant
//   mem_A, mem_WD, mem_WE          memory address, write data, write enable
//   mem_RD                         memory read data, combinational from mem_A
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int DEPTH         = 1024,
   parameter int CORE_PRIORITY = 1,
   parameter int MAX_WAIT      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   output logic        gnt0,
   output logic        rvalid0,
   output logic [31:0] rdata0,
   output logic        err0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        gnt1,
   output logic        rvalid1,
   output logic [31:0] rdata1,
   output logic        err1,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   input  logic [31:0] mem_RD
);

   localparam logic [31:0] DEPTH_W    = 32'(DEPTH);
   localparam logic [3:0]  MAX_WAIT_W = 4'(MAX_WAIT);

   logic [1:0]  req_vec;
   logic [1:0]  we_vec;
   logic [1:0]  in_range;
   logic [1:0]  gnt_vec;
   logic [31:0] addr_arr [2];

   assign req_vec     = {req1, req0};
   assign we_vec      = {we1, we0};
   assign addr_arr[0] = addr0;
   assign addr_arr[1] = addr1;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_range
         assign in_range[gi] = addr_arr[gi] < DEPTH_W;
      end
   endgenerate

   // Arbiter state: the round-robin pointer (1 = port 1 wins the next
   // contention) and the number of consecutive cycles port 1 has been denied.
   logic       rr_ptr_reg,   rr_ptr_next;
   logic [3:0] wait_cnt_reg, wait_cnt_next;
   logic       pick1;

   // pick1 decides port 1 against port 0. The result is then masked with rst
   // so that the grants, and the write enable derived from them, drop as soon
   // as reset is asserted, and not at the next clock edge.
   generate
      if (CORE_PRIORITY != 0) begin : g_pri
         assign pick1 = req_vec[1] & (~req_vec[0] | (wait_cnt_reg == MAX_WAIT_W));
      end else begin : g_rr
         assign pick1 = req_vec[1] & (~req_vec[0] | rr_ptr_reg);
      end
   endgenerate

   assign gnt_vec[1] = pick1 & ~rst;
   assign gnt_vec[0] = req_vec[0] & ~pick1 & ~rst;
   assign gnt0       = gnt_vec[0];
   assign gnt1       = gnt_vec[1];

   // The memory address and write data follow port 0 unless port 1 holds the
   // grant. Both are forced to zero while reset is asserted.
   always_comb begin
      mem_A  = '0;
      mem_WD = '0;
      if (gnt_vec[1]) begin
         mem_A  = addr1;
         mem_WD = wdata1;
      end else if (!rst) begin
         mem_A  = addr0;
         mem_WD = wdata0;
      end
   end

   assign mem_WE = |(gnt_vec & we_vec & in_range);

   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (gnt_vec[0]) begin
         rr_ptr_next = 1'b1;
      end else if (gnt_vec[1]) begin
         rr_ptr_next = 1'b0;
      end

      wait_cnt_next = wait_cnt_reg;
      if (!req_vec[1] || gnt_vec[1]) begin
         wait_cnt_next = '0;
      end else if (wait_cnt_reg != MAX_WAIT_W) begin
         wait_cnt_next = wait_cnt_reg + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_reg   <= 1'b0;
         wait_cnt_reg <= '0;
      end else begin
         rr_ptr_reg   <= rr_ptr_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // Response path for each port. rdata is loaded only on that port's own
   // grant, so it keeps its last value between responses. Writes and rejected
   // accesses load zero.
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic        rvalid_reg;
         logic        err_reg;
         logic [31:0] rdata_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rvalid_reg <= 1'b0;
               err_reg    <= 1'b0;
               rdata_reg  <= '0;
            end else begin
               rvalid_reg <= gnt_vec[gi];
               err_reg    <= gnt_vec[gi] & ~in_range[gi];
               if (gnt_vec[gi]) begin
                  rdata_reg <= (we_vec[gi] | ~in_range[gi]) ? 32'd0 : mem_RD;
               end
            end
         end
      end
   endgenerate

   assign rvalid0 = g_port[0].rvalid_reg;
   assign err0    = g_port[0].err_reg;
   assign rdata0  = g_port[0].rdata_reg;
   assign rvalid1 = g_port[1].rvalid_reg;
   assign err1    = g_port[1].err_reg;
   assign rdata1  = g_port[1].rdata_reg;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter sharing the single-ported data memory between the core load/store unit (port 0) and a DMA/debug loader (port 1).
- Grants at most one access per cycle and drives the memory address, write data and write enable.
- Registers read data back to the winning requester with one-cycle latency.
- Policy is either round-robin, or core-priority with a starvation guard for port 1.
- Rejects out-of-range addresses with an error response.

Parameters:
DEPTH, 1024, number of 32-bit words in data memory; legal word addresses are 0..DEPTH-1.
CORE_PRIORITY, 1, 1 = fixed priority to port 0 with starvation guard; 0 = round-robin.
MAX_WAIT, 4, consecutive cycles port 1 may be denied under CORE_PRIORITY before it is forced to win (range 1..15).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req0  input  1  port 0 request
we0  input  1  port 0 write (1) / read (0)
addr0  input  32  port 0 word address
wdata0  input  32  port 0 write data
gnt0  output  1  port 0 granted this cycle (combinational)
rvalid0  output  1  port 0 response valid (registered pulse)
rdata0  output  32  port 0 read data
err0  output  1  port 0 address error, valid with rvalid0
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1, err1  same as port 0, for port 1
mem_A  output  32  memory word address
mem_WD  output  32  memory write data
mem_WE  output  1  memory write enable
mem_RD  input  32  memory read data, combinational from mem_A

Behaviour:
- Reset (async, rst=1):
  - gnt0/1=0, mem_WE=0, mem_A=0, mem_WD=0.
  - rvalid0/1=0, rdata0/1=0, err0/1=0.
  - RR pointer=port 0, wait counter=0.
  - Reset asserted mid-transaction drops that transaction: no write, no response.
- Handshake:
  - A transfer occurs in any cycle where reqN=1 and gntN=1.
  - Requesters hold req, we, addr and wdata stable until granted.
  - gnt is combinational from req and arbiter state; never both gnt=1.
  - gntN=0 whenever reqN=0.
- Arbitration, one requester: that requester is granted.
- Arbitration, both requesting, CORE_PRIORITY=0:
  - The grant goes to the pointer port.
  - After any grant, the pointer becomes the other port, so back-to-back contention alternates 0,1,0,1.
- Arbitration, both requesting, CORE_PRIORITY=1:
  - Port 0 wins unless wait counter == MAX_WAIT, in which case port 1 wins.
  - Wait counter increments each cycle req1=1 and gnt1=0 (saturating at MAX_WAIT).
  - Wait counter clears on gnt1 or when req1=0.
- Mux:
  - mem_A and mem_WD follow the granted port; they follow port 0 when there is no grant.
  - mem_WE = granted port's we AND addr < DEPTH.
- Out-of-range access (addr >= DEPTH):
  - Still granted (one cycle consumed), no memory write.
  - Next cycle: rvalid=1, err=1, rdata=0.
- Response:
  - Every granted transfer (read or write) produces rvalidN=1 for exactly one cycle, the cycle after the grant.
  - Reads: rdataN = mem_RD sampled at the grant edge.
  - Writes: rdataN = 0, errN = 0 when in range.
  - Non-pulsing port holds rvalid=0, err=0; rdata retains its last value.
- Throughput:
  - One transfer per cycle, no bubbles.
  - A requester may issue a new request in the same cycle as its previous rvalid.
- Read-after-write, same address, consecutive grants: the read returns the new data (the write commits at the first edge).

Test Plan:
1. Reset then port 0 alone: write addr0=28, wdata0=0x00000020, then read addr0=28 → gnt0 each cycle; mem_WE=1 in write cycle; rvalid0 on both following cycles; read rdata0=0x00000020, err0=0.
2. CORE_PRIORITY=0, req0=req1=1 held 6 cycles (reads addr 40/41) → grants 0,1,0,1,0,1; rvalid alternates one cycle later with correct data per port.
3. CORE_PRIORITY=1, MAX_WAIT=4, both requesting continuously → gnt0 for 4 cycles, gnt1 on 5th, counter clears, pattern repeats; no cycle with both grants.
4. Port 1 write addr1=1024 (DEPTH=1024) → gnt1=1, mem_WE=0; next cycle rvalid1=1, err1=1, rdata1=0; memory contents unchanged (readback of addr 0 unaffected).
5. rst asserted asynchronously mid-cycle while gnt1=1 for a write → gnt1, mem_WE and rvalid drop immediately; target word unchanged; after release, pointer=0 and counter=0.
6. Back-to-back write then read same addr 40 from port 0 (0x2 → 0x5) → second response rdata0=0x00000005.
